hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 29-bit-instruction processor (fetch → ID/EX → WB result register → register-file write).
- Watches the instruction in the instruction register (ID stage).
- Tracks the destinations of the two instructions ahead of it.
- Resolves read-after-write hazards by operand forwarding, or by stall/bubble insertion when forwarding is disabled.
- Flushes the wrong-path fetch after a jump.
- Sits beside the control unit and drives PC/IR enables, the write-enable kill and the ALU operand forward muxes.

---
 rtl/processor_pkg.sv | 47 ++++
 rtl/hazard_decode.sv | 20 ++
 rtl/hazard_ctrl.sv | 108 ++++++++++
 tb/tb_hazard_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/processor_pkg.sv
// Shared definitions for the 29-bit processor: opcodes, instruction fields,
// forward-mux encodings and hazard FSM states.
package processor_pkg;

    localparam int INSTR_W = 29;
    localparam int OP_HI   = 28;
    localparam int OP_LO   = 24;
    localparam int DST_HI  = 23;
    localparam int DST_LO  = 16;
    localparam int S1_HI   = 15;
    localparam int S1_LO   = 8;
    localparam int S2_HI   = 7;
    localparam int S2_LO   = 0;

    typedef logic [4:0] opcode_t;
    localparam opcode_t OP_NOP  = 5'd0;
    localparam opcode_t OP_ADD  = 5'd1;
    localparam opcode_t OP_SUB  = 5'd2;
    localparam opcode_t OP_AND  = 5'd3;
    localparam opcode_t OP_OR   = 5'd4;
    localparam opcode_t OP_ADDI = 5'd5;
    localparam opcode_t OP_JMP  = 5'd6;

    typedef logic [1:0] fwd_sel_t;
    localparam fwd_sel_t FWD_RF   = 2'b00;
    localparam fwd_sel_t FWD_WB   = 2'b01;
    localparam fwd_sel_t FWD_WBUS = 2'b10;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } hz_state_e;

    typedef struct packed {
        logic       vld;
        logic [7:0] addr;
    } pend_t;

    typedef struct packed {
        logic rd1;
        logic rd2;
        logic wr;
        logic jmp;
    } dec_t;

endpackage

// File: rtl/hazard_decode.sv
// Opcode classifier: which register fields an instruction reads/writes and
// whether it is a jump. Shared with the control unit.
module hazard_decode
    import processor_pkg::*;
(
    input  opcode_t opcode,
    output dec_t    dec
);

    always_comb begin
        dec = '0;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR: dec = '{rd1: 1'b1, rd2: 1'b1, wr: 1'b1, jmp: 1'b0};
            OP_ADDI:                       dec = '{rd1: 1'b1, rd2: 1'b0, wr: 1'b1, jmp: 1'b0};
            OP_JMP:                        dec = '{rd1: 1'b0, rd2: 1'b0, wr: 1'b0, jmp: 1'b1};
            default:                       dec = '0;
        endcase
    end

endmodule

// File: rtl/hazard_ctrl.sv
// RAW hazard controller for the ID stage: forwards from WB/write bus or stalls,
// and flushes the wrong-path fetch after a jump.
module hazard_ctrl
    import processor_pkg::*;
#(
    parameter bit FWD_EN = 1'b1,
    parameter int CNT_W  = 16
) (
    input  logic               in_clk,
    input  logic               in_rst,
    input  logic [28:0]        in_instr,
    input  logic               in_instr_valid,
    output logic               out_pc_en,
    output logic               out_bubble,
    output logic               out_flush,
    output logic [1:0]         out_fwd_sel_1,
    output logic [1:0]         out_fwd_sel_2,
    output logic [CNT_W-1:0]   out_stall_cnt
);

    hz_state_e  state, state_nxt;
    logic [1:0] cnt, cnt_nxt;
    pend_t      ent_e, ent_w;
    dec_t       dec_raw, dec;
    logic       live;
    logic [7:0] src1, src2;
    logic       m1_e, m2_e, m1_w, m2_w, hit_e, hit_w;

    hazard_decode u_dec (
        .opcode (in_instr[OP_HI:OP_LO]),
        .dec    (dec_raw)
    );

    // Reset is folded in so a jump sitting in ID cannot raise flush while held in reset.
    assign live = in_instr_valid && in_rst && (state != ST_FLUSH);
    assign dec  = live ? dec_raw : '0;
    assign src1 = in_instr[S1_HI:S1_LO];
    assign src2 = in_instr[S2_HI:S2_LO];

    assign m1_e  = dec.rd1 && ent_e.vld && (ent_e.addr == src1);
    assign m2_e  = dec.rd2 && ent_e.vld && (ent_e.addr == src2);
    assign m1_w  = dec.rd1 && ent_w.vld && (ent_w.addr == src1);
    assign m2_w  = dec.rd2 && ent_w.vld && (ent_w.addr == src2);
    assign hit_e = m1_e || m2_e;
    assign hit_w = m1_w || m2_w;

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        out_pc_en     = 1'b1;
        out_bubble    = 1'b0;
        out_flush     = 1'b0;
        out_fwd_sel_1 = FWD_RF;
        out_fwd_sel_2 = FWD_RF;
        case (state)
            ST_RUN: begin
                if (!FWD_EN && hit_e) begin
                    out_pc_en  = 1'b0;
                    out_bubble = 1'b1;
                    state_nxt  = ST_STALL;
                    cnt_nxt    = 2'd1;
                end else if (!FWD_EN && hit_w) begin
                    out_pc_en  = 1'b0;
                    out_bubble = 1'b1;
                end else if (dec.jmp) begin
                    out_flush = 1'b1;
                    state_nxt = ST_FLUSH;
                end
            end
            ST_STALL: begin
                out_pc_en  = 1'b0;
                out_bubble = 1'b1;
                if (cnt <= 2'd1) begin
                    state_nxt = ST_RUN;
                    cnt_nxt   = 2'd0;
                end else begin
                    cnt_nxt = cnt - 2'd1;
                end
            end
            ST_FLUSH: state_nxt = ST_RUN;
            default:  state_nxt = ST_RUN;
        endcase
        // E holds the younger result, so it wins over W.
        if (FWD_EN) begin
            out_fwd_sel_1 = m1_e ? FWD_WB : (m1_w ? FWD_WBUS : FWD_RF);
            out_fwd_sel_2 = m2_e ? FWD_WB : (m2_w ? FWD_WBUS : FWD_RF);
        end
    end

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            state         <= ST_RUN;
            cnt           <= 2'd0;
            ent_e         <= '0;
            ent_w         <= '0;
            out_stall_cnt <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            ent_w     <= ent_e;
            ent_e.vld <= dec.wr && !out_bubble;
            ent_e.addr <= in_instr[DST_HI:DST_LO];
            if (out_bubble && !(&out_stall_cnt))
                out_stall_cnt <= out_stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench: forwarding and stalling instances driven from instruction streams,
// checked against an issue-history reference model through a scoreboard.
module tb_hazard_ctrl;
    import processor_pkg::*;

    localparam int CW0 = 16;
    localparam int CW1 = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [28:0] instr0 = '0, instr1 = '0;
    logic        vld0 = 1'b0, vld1 = 1'b0;
    logic        pc0, pc1, bub0, bub1, fl0, fl1;
    logic [1:0]  s10, s20, s11, s21;
    logic [CW0-1:0] cnt0;
    logic [CW1-1:0] cnt1;

    hazard_ctrl #(.FWD_EN(1'b1), .CNT_W(CW0)) u_fwd (
        .in_clk(clk), .in_rst(rst_n), .in_instr(instr0), .in_instr_valid(vld0),
        .out_pc_en(pc0), .out_bubble(bub0), .out_flush(fl0),
        .out_fwd_sel_1(s10), .out_fwd_sel_2(s20), .out_stall_cnt(cnt0));

    hazard_ctrl #(.FWD_EN(1'b0), .CNT_W(CW1)) u_stl (
        .in_clk(clk), .in_rst(rst_n), .in_instr(instr1), .in_instr_valid(vld1),
        .out_pc_en(pc1), .out_bubble(bub1), .out_flush(fl1),
        .out_fwd_sel_1(s11), .out_fwd_sel_2(s21), .out_stall_cnt(cnt1));

    typedef struct {
        int       id;
        bit       pc_en;
        bit       bub;
        bit       fl;
        bit [1:0] s1;
        bit [1:0] s2;
        int       cnt;
    } exp_t;

    exp_t sb[$];
    int vecs = 0;
    int errs = 0;

    // model state: h1/h2 = dest issued 1/2 cycles ago (-1 = none)
    int          h1[2], h2[2], need[2], nbub[2];
    bit          in_fl[2];
    logic [28:0] cur_i[2];
    bit          cur_v[2];
    logic [29:0] prog0[$], prog1[$];

    function automatic logic [29:0] mk(int op, int d, int a, int b);
        logic [29:0] r;
        r = {1'b1, op[4:0], d[7:0], a[7:0], b[7:0]};
        return r;
    endfunction

    function automatic logic [29:0] rnd();
        logic [29:0] r;
        r[29]    = ($urandom_range(0, 9) != 0);
        r[28:24] = 5'($urandom_range(0, 7));
        r[23:16] = 8'($urandom_range(0, 3));
        r[15:8]  = 8'($urandom_range(0, 3));
        r[7:0]   = 8'($urandom_range(0, 3));
        return r;
    endfunction

    function automatic int maxc(int id);
        return (id == 0) ? (1 << CW0) - 1 : (1 << CW1) - 1;
    endfunction

    task automatic load(int id, logic [29:0] w);
        cur_v[id] = w[29];
        cur_i[id] = w[28:0];
    endtask

    task automatic next_instr(int id);
        if (id == 0 && prog0.size() != 0)      load(id, prog0.pop_front());
        else if (id == 1 && prog1.size() != 0) load(id, prog1.pop_front());
        else                                   load(id, rnd());
    endtask

    task automatic drive(int id);
        if (id == 0) begin instr0 = cur_i[0]; vld0 = cur_v[0]; end
        else         begin instr1 = cur_i[1]; vld1 = cur_v[1]; end
    endtask

    task automatic model_reset(int id);
        h1[id] = -1; h2[id] = -1; need[id] = -1; nbub[id] = 0; in_fl[id] = 0;
    endtask

    function automatic exp_t reset_exp(int id);
        exp_t e;
        e.id = id; e.pc_en = 1; e.bub = 0; e.fl = 0; e.s1 = 0; e.s2 = 0; e.cnt = 0;
        return e;
    endfunction

    task automatic model(int id);
        exp_t e;
        bit adv, rd1, rd2, wr, jmp, m1e, m2e, m1w, m2w;
        int nd, op, d, a, b;
        adv = 0; nd = -1;
        op = int'(cur_i[id][28:24]); d = int'(cur_i[id][23:16]);
        a  = int'(cur_i[id][15:8]);  b = int'(cur_i[id][7:0]);
        e = reset_exp(id);
        e.cnt = (nbub[id] > maxc(id)) ? maxc(id) : nbub[id];
        if (in_fl[id]) begin
            in_fl[id] = 0;
            adv = 1;
        end else begin
            rd1 = cur_v[id] && op >= 1 && op <= 5;
            rd2 = cur_v[id] && op >= 1 && op <= 4;
            wr  = rd1;
            jmp = cur_v[id] && op == 6;
            m1e = rd1 && h1[id] == a;  m2e = rd2 && h1[id] == b;
            m1w = rd1 && h2[id] == a;  m2w = rd2 && h2[id] == b;
            if (id == 0) begin
                e.s1 = m1e ? 2'b01 : (m1w ? 2'b10 : 2'b00);
                e.s2 = m2e ? 2'b01 : (m2w ? 2'b10 : 2'b00);
                adv = 1;
            end else begin
                if (need[id] < 0) need[id] = (m1e || m2e) ? 2 : ((m1w || m2w) ? 1 : 0);
                if (need[id] > 0) begin
                    e.pc_en = 0; e.bub = 1; need[id]--;
                end else adv = 1;
            end
            if (adv) begin
                nd = wr ? d : -1;
                e.fl = jmp; in_fl[id] = jmp; need[id] = -1;
            end
        end
        h2[id] = h1[id]; h1[id] = nd;
        if (e.bub) nbub[id]++;
        sb.push_back(e);
        if (adv) begin
            if (in_fl[id]) load(id, rnd());
            else           next_instr(id);
        end
    endtask

    task automatic chk(exp_t e);
        bit ap, ab, af;
        bit [1:0] a1, a2;
        int ac;
        if (e.id == 0) begin ap = pc0; ab = bub0; af = fl0; a1 = s10; a2 = s20; ac = int'(cnt0); end
        else           begin ap = pc1; ab = bub1; af = fl1; a1 = s11; a2 = s21; ac = int'(cnt1); end
        vecs++;
        if (ap !== e.pc_en || ab !== e.bub || af !== e.fl || a1 !== e.s1 || a2 !== e.s2 || ac != e.cnt) begin
            errs++;
            $display("FAIL dut%0d t=%0t got pc_en=%0b bub=%0b flush=%0b sel1=%0d sel2=%0d cnt=%0d want pc_en=%0b bub=%0b flush=%0b sel1=%0d sel2=%0d cnt=%0d",
                     e.id, $time, ap, ab, af, a1, a2, ac, e.pc_en, e.bub, e.fl, e.s1, e.s2, e.cnt);
        end
    endtask

    always @(negedge clk) begin
        while (sb.size() != 0) chk(sb.pop_front());
    end

    task automatic dir_prog(int id, logic [29:0] w);
        if (id == 0) prog0.push_back(w); else prog1.push_back(w);
    endtask

    task automatic cycles(int n);
        for (int c = 0; c < n; c++) begin
            rst_n = 1'b1;
            for (int id = 0; id < 2; id++) begin drive(id); model(id); end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        bit done;
        for (int id = 0; id < 2; id++) begin
            model_reset(id);
            dir_prog(id, mk(OP_ADD, 3, 1, 2));  dir_prog(id, mk(OP_ADD, 4, 3, 1));
            dir_prog(id, mk(OP_NOP, 0, 0, 0));  dir_prog(id, mk(OP_NOP, 0, 0, 0));
            dir_prog(id, mk(OP_ADD, 3, 1, 2));  dir_prog(id, mk(OP_NOP, 0, 0, 0));
            dir_prog(id, mk(OP_ADD, 4, 3, 1));
            dir_prog(id, mk(OP_NOP, 0, 0, 0));  dir_prog(id, mk(OP_NOP, 0, 0, 0));
            dir_prog(id, mk(OP_ADD, 3, 1, 2));  dir_prog(id, mk(OP_ADD, 6, 1, 2));
            dir_prog(id, mk(OP_SUB, 5, 2, 3));
            dir_prog(id, mk(OP_NOP, 0, 0, 0));  dir_prog(id, mk(OP_NOP, 0, 0, 0));
            dir_prog(id, mk(OP_ADD, 3, 1, 2));  dir_prog(id, mk(OP_ADD, 3, 1, 2));
            dir_prog(id, mk(OP_SUB, 5, 2, 3));
            dir_prog(id, mk(OP_NOP, 0, 0, 0));  dir_prog(id, mk(OP_NOP, 0, 0, 0));
            dir_prog(id, mk(OP_ADD, 9, 1, 2));  dir_prog(id, mk(OP_ADDI, 1, 2, 9));
            dir_prog(id, mk(OP_NOP, 0, 0, 0));  dir_prog(id, mk(OP_NOP, 0, 0, 0));
            dir_prog(id, mk(OP_JMP, 8'h20, 0, 0));
            dir_prog(id, mk(OP_ADD, 7, 1, 2));
            next_instr(id);
            drive(id);
        end
        #1;
        chk(reset_exp(0));
        chk(reset_exp(1));
        repeat (2) @(posedge clk);
        #1;
        cycles(400);

        // reset during the second cycle of a two-bubble stall
        prog1.push_front(mk(OP_ADD, 4, 3, 1));
        prog1.push_front(mk(OP_ADD, 3, 1, 2));
        done = 0;
        for (int c = 0; c < 80 && !done; c++) begin
            if (need[1] == 1) begin
                for (int id = 0; id < 2; id++) drive(id);
                rst_n = 1'b0;
                #1;
                chk(reset_exp(0));
                chk(reset_exp(1));
                for (int id = 0; id < 2; id++) begin
                    model_reset(id);
                    sb.push_back(reset_exp(id));
                end
                @(posedge clk); #1;
                done = 1;
            end else begin
                cycles(1);
            end
        end
        vecs++;
        if (!done) begin
            errs++;
            $display("FAIL stall_reset: got no two-bubble stall within 80 cycles, want one");
        end
        cycles(400);
        @(negedge clk); #1;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
